// File: rtl/micro_sequencer_if.sv
// Microinstruction-field and status bundle between the microstore/datapath
// side (master) and the micro_sequencer (slave).
interface micro_sequencer_if;
    logic [2:0] ns_sel;
    logic [6:0] cr_addr;
    logic [1:0] cond_sel;
    logic       inv;
    logic [5:0] opcode;
    logic       moc;
    logic       zero;
    logic       neg;
    logic       cond_ext;
    logic [6:0] current_state;
    logic       illegal_op;
    logic       moc_timeout;

    // Microstore/datapath side: supplies instruction fields and status, reads the state
    modport master (
        output ns_sel, cr_addr, cond_sel, inv, opcode, moc, zero, neg, cond_ext,
        input  current_state, illegal_op, moc_timeout
    );

    // Sequencer side: consumes fields and status, produces the state number and flags
    modport slave (
        input  ns_sel, cr_addr, cond_sel, inv, opcode, moc, zero, neg, cond_ext,
        output current_state, illegal_op, moc_timeout
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: chooses the next microstore address from the
// current microinstruction's next-state field, with opcode dispatch,
// conditional branch, bounded MOC wait, and a single-level call/return.
module micro_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'b000,
        NS_RESTART  = 3'b001,
        NS_JUMP     = 3'b010,
        NS_NEXT     = 3'b011,
        NS_BRANCH   = 3'b100,
        NS_WAIT     = 3'b101,
        NS_CALL     = 3'b110,
        NS_RETURN   = 3'b111
    } ns_sel_e;

    // Wait count value at which one more false cycle means the wait has expired
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [6:0] r_currentState;
    logic [6:0] r_retReg;
    logic [7:0] r_waitCnt;
    logic       r_illegalOp;
    logic       r_mocTimeout;

    logic [6:0] w_nextState;
    logic [6:0] w_nextRet;
    logic [7:0] w_nextWait;
    logic       w_nextIllegal;
    logic       w_nextTimeout;

    logic [6:0] w_inc;
    logic [6:0] w_dispatchState;
    logic       w_dispatchValid;
    logic       w_condRaw;
    logic       w_cond;

    assign w_inc = r_currentState + 7'd1;
    assign w_cond = w_condRaw ^ bus.inv;

    // Select the status condition named by cond_sel
    always_comb begin
        w_condRaw = 1'b0;
        case (bus.cond_sel)
            2'b00:   w_condRaw = bus.moc;
            2'b01:   w_condRaw = bus.zero;
            2'b10:   w_condRaw = bus.neg;
            default: w_condRaw = bus.cond_ext;
        endcase
    end

    // Map the instruction opcode to its entry state; unknown opcodes go to 0 and are flagged
    always_comb begin
        w_dispatchState = 7'd0;
        w_dispatchValid = 1'b1;
        case (bus.opcode)
            6'b000000: w_dispatchState = 7'd5;
            6'b100011: w_dispatchState = 7'd6;
            6'b101011: w_dispatchState = 7'd7;
            6'b000100: w_dispatchState = 7'd8;
            6'b000010: w_dispatchState = 7'd9;
            6'b001000: w_dispatchState = 7'd10;
            default: begin
                w_dispatchState = 7'd0;
                w_dispatchValid = 1'b0;
            end
        endcase
    end

    // State register plus return address, wait counter and the two flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_currentState <= 7'd0;
            r_retReg       <= 7'd0;
            r_waitCnt      <= 8'd0;
            r_illegalOp    <= 1'b0;
            r_mocTimeout   <= 1'b0;
        end else begin
            r_currentState <= w_nextState;
            r_retReg       <= w_nextRet;
            r_waitCnt      <= w_nextWait;
            r_illegalOp    <= w_nextIllegal;
            r_mocTimeout   <= w_nextTimeout;
        end
    end

    // Next-state selection; wait count only survives consecutive WAIT cycles
    always_comb begin
        w_nextState   = r_currentState;
        w_nextRet     = r_retReg;
        w_nextWait    = 8'd0;
        w_nextIllegal = 1'b0;
        w_nextTimeout = r_mocTimeout;
        case (ns_sel_e'(bus.ns_sel))
            NS_DISPATCH: begin
                w_nextState   = w_dispatchState;
                w_nextIllegal = ~w_dispatchValid;
            end
            NS_RESTART: w_nextState = 7'd0;
            NS_JUMP:    w_nextState = bus.cr_addr;
            NS_NEXT:    w_nextState = w_inc;
            NS_BRANCH:  w_nextState = w_cond ? bus.cr_addr : w_inc;
            NS_WAIT: begin
                if (w_cond) begin
                    w_nextState = w_inc;
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_nextState   = 7'd0;
                    w_nextTimeout = 1'b1;
                end else begin
                    w_nextState = r_currentState;
                    w_nextWait  = r_waitCnt + 8'd1;
                end
            end
            NS_CALL: begin
                w_nextState = bus.cr_addr;
                w_nextRet   = w_inc;
            end
            NS_RETURN:  w_nextState = r_retReg;
            default:    w_nextState = 7'd0;
        endcase
    end

    // Outputs come straight from registers so they are glitch-free microstore addresses
    always_comb begin
        bus.current_state = r_currentState;
        bus.illegal_op    = r_illegalOp;
        bus.moc_timeout   = r_mocTimeout;
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed microinstruction sequences checked
// every cycle against a behavioural model, plus hand-computed spot checks.
module tb_micro_sequencer;

    localparam int TO = 16;
    localparam int OPS[6] = '{0, 35, 43, 4, 2, 8};

    typedef struct {
        int st;
        int ret;
        int wt;
        bit ill;
        bit to;
    } model_t;

    logic clk;
    logic reset;
    bit   armed;
    int   errors;
    int   checks;
    model_t m;

    micro_sequencer_if bus ();

    micro_sequencer #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural next-state rule written from the sequencer's definition
    function automatic model_t modelStep(model_t c, int ns, int cr, int cs, bit iv, int op,
                                         bit mc, bit z, bit n, bit e);
        model_t r = c;
        bit srcs[4];
        bit cond;
        int inc;
        srcs = '{mc, z, n, e};
        cond = srcs[cs] ^ iv;
        inc  = (c.st + 1) % 128;
        r.ill = 1'b0;
        if (ns != 5) r.wt = 0;
        case (ns)
            0: begin
                r.st  = 0;
                r.ill = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (OPS[i] == op) begin
                        r.st  = 5 + i;
                        r.ill = 1'b0;
                    end
                end
            end
            1: r.st = 0;
            2: r.st = cr;
            3: r.st = inc;
            4: r.st = cond ? cr : inc;
            5: begin
                if (cond) begin
                    r.st = inc;
                    r.wt = 0;
                end else if (c.wt + 1 >= TO) begin
                    r.st = 0;
                    r.to = 1'b1;
                    r.wt = 0;
                end else begin
                    r.wt = c.wt + 1;
                end
            end
            6: begin
                r.st  = cr;
                r.ret = inc;
            end
            default: r.st = c.ret;
        endcase
        return r;
    endfunction

    // Model follows the DUT's clock and asynchronous reset
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m <= '{0, 0, 0, 1'b0, 1'b0};
        end else begin
            m <= modelStep(m, int'(bus.ns_sel), int'(bus.cr_addr), int'(bus.cond_sel),
                           bus.inv, int'(bus.opcode), bus.moc, bus.zero, bus.neg, bus.cond_ext);
        end
    end

    task automatic compareVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every falling edge out of reset, the DUT must agree with the model
    always @(negedge clk) begin
        if (armed && reset === 1'b1) begin
            compareVal("model.state",   int'(bus.current_state), m.st);
            compareVal("model.illegal", int'(bus.illegal_op),    int'(m.ill));
            compareVal("model.timeout", int'(bus.moc_timeout),   int'(m.to));
        end
    end

    task automatic checkOutput(input string name, input int st, input int ill, input int to);
        compareVal({name, ".state"},   int'(bus.current_state), st);
        compareVal({name, ".illegal"}, int'(bus.illegal_op),    ill);
        compareVal({name, ".timeout"}, int'(bus.moc_timeout),   to);
    endtask

    // Drive one microinstruction, let one rising edge take it, return just after the falling edge
    task automatic applyStimulus(input logic [2:0] ns, input logic [6:0] cr, input logic [1:0] cs,
                                 input logic iv, input logic [5:0] op, input logic mc,
                                 input logic z, input logic n, input logic e);
        bus.ns_sel   = ns;
        bus.cr_addr  = cr;
        bus.cond_sel = cs;
        bus.inv      = iv;
        bus.opcode   = op;
        bus.moc      = mc;
        bus.zero     = z;
        bus.neg      = n;
        bus.cond_ext = e;
        @(negedge clk);
        #1;
    endtask

    task automatic doSimple(input logic [2:0] ns, input logic [6:0] cr);
        applyStimulus(ns, cr, 2'b00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doWait(input logic mc);
        applyStimulus(3'b101, 7'd0, 2'b00, 1'b0, 6'd0, mc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        checkOutput("reset_async", 0, 0, 0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        armed  = 1'b0;
        reset  = 1'b1;
        bus.ns_sel = 3'b011; bus.cr_addr = 7'd0; bus.cond_sel = 2'b00; bus.inv = 1'b0;
        bus.opcode = 6'd0; bus.moc = 1'b0; bus.zero = 1'b0; bus.neg = 1'b0; bus.cond_ext = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_initial", 0, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        armed = 1'b1;

        doSimple(3'b011, 7'd0);
        checkOutput("first_next", 1, 0, 0);

        // Asynchronous reset from state 9, then NEXT from 0
        doSimple(3'b010, 7'd9);
        checkOutput("jump9", 9, 0, 0);
        pulseReset();
        doSimple(3'b011, 7'd0);
        checkOutput("after_reset_next", 1, 0, 0);

        // Dispatch sweep
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b000, 7'd0, 2'b00, 1'b0, 6'(OPS[i]), 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("dispatch", 5 + i, 0, 0);
        end

        // Illegal dispatch: single pulse, then back-to-back
        applyStimulus(3'b000, 7'd0, 2'b00, 1'b0, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("illegal1", 0, 1, 0);
        doSimple(3'b011, 7'd0);
        checkOutput("illegal1_end", 1, 0, 0);
        applyStimulus(3'b000, 7'd0, 2'b00, 1'b0, 6'b010101, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 7'd0, 2'b00, 1'b0, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("illegal_b2b", 0, 1, 0);
        doSimple(3'b011, 7'd0);
        checkOutput("illegal_b2b_end", 1, 0, 0);

        // Wait count restarts when the WAIT run is broken
        doSimple(3'b010, 7'd3);
        for (int i = 0; i < 10; i++) doWait(1'b0);
        doSimple(3'b010, 7'd3);
        for (int i = 0; i < 15; i++) doWait(1'b0);
        checkOutput("wait_restart", 3, 0, 0);

        // Wait release on the 4th cycle
        doSimple(3'b010, 7'd3);
        for (int i = 0; i < 3; i++) doWait(1'b0);
        checkOutput("wait_hold3", 3, 0, 0);
        doWait(1'b1);
        checkOutput("wait_release", 4, 0, 0);

        // Timeout: 15 holds, 16th false edge forces 0 and sets the sticky flag
        doSimple(3'b010, 7'd3);
        for (int i = 0; i < 15; i++) doWait(1'b0);
        checkOutput("wait_hold15", 3, 0, 0);
        doWait(1'b0);
        checkOutput("timeout", 0, 0, 1);
        doSimple(3'b011, 7'd0);
        checkOutput("timeout_sticky", 1, 0, 1);
        doSimple(3'b010, 7'd3);
        for (int i = 0; i < 16; i++) doWait(1'b0);
        checkOutput("timeout_again", 0, 0, 1);
        pulseReset();
        doSimple(3'b011, 7'd0);
        checkOutput("timeout_cleared", 1, 0, 0);

        // Inverted MOC condition: moc=0 with inv=1 releases immediately
        doSimple(3'b010, 7'd3);
        applyStimulus(3'b101, 7'd0, 2'b00, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wait_inv", 4, 0, 0);

        // Branch not taken, call, return
        doSimple(3'b010, 7'd2);
        applyStimulus(3'b100, 7'd40, 2'b01, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_not_taken", 3, 0, 0);
        doSimple(3'b110, 7'd20);
        checkOutput("call", 20, 0, 0);
        doSimple(3'b011, 7'd0);
        doSimple(3'b111, 7'd0);
        checkOutput("return", 4, 0, 0);

        // Branch taken on neg and on cond_ext
        doSimple(3'b010, 7'd2);
        applyStimulus(3'b100, 7'd40, 2'b10, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("branch_neg", 40, 0, 0);
        applyStimulus(3'b100, 7'd99, 2'b11, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("branch_ext", 99, 0, 0);

        // Second CALL overwrites the return address; RETURN leaves it intact
        doSimple(3'b010, 7'd4);
        doSimple(3'b110, 7'd50);
        doSimple(3'b110, 7'd60);
        doSimple(3'b111, 7'd0);
        checkOutput("call_overwrite", 51, 0, 0);
        doSimple(3'b111, 7'd0);
        checkOutput("return_again", 51, 0, 0);

        // Wrap and restart
        doSimple(3'b010, 7'd127);
        doSimple(3'b011, 7'd0);
        checkOutput("wrap", 0, 0, 0);
        doSimple(3'b010, 7'd30);
        doSimple(3'b001, 7'd0);
        checkOutput("restart", 0, 0, 0);

        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum consecutive MOC wait cycles (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 ns_sel  input  3  next-state select field from the current microinstruction.
REQ-005 cr_addr  input  7  literal target state from the current microinstruction.
REQ-006 cond_sel  input  2  condition source: 00 moc, 01 zero, 10 neg, 11 cond_ext.
REQ-007 inv  input  1  inverts the selected condition.
REQ-008 opcode  input  6  instruction opcode for dispatch.
REQ-009 moc  input  1  memory operation complete.
REQ-010 zero, neg, cond_ext  input  1 each  status conditions.
REQ-011 current_state  output  7  registered state number; drives the microstore address.
REQ-012 illegal_op  output  1  registered one-cycle pulse on unknown opcode dispatch.
REQ-013 moc_timeout  output  1  sticky MOC timeout flag.

Function
REQ-014 Internal regs SHALL be current_state, ret_reg[6:0] (1-deep return), wait_cnt[7:0], illegal_op, moc_timeout.
REQ-015 inc = current_state+1 mod 128 (127 wraps to 0); cond = mux(cond_sel) XOR inv.
REQ-016 ns_sel 000 DISPATCH: next = encoder(opcode).
REQ-017 Encoder: 000000->5, 100011->6, 101011->7, 000100->8, 000010->9, 001000->10; others->0 with illegal_op=1 next cycle.
REQ-018 ns_sel 001 RESTART: next = 0.
REQ-019 ns_sel 010 JUMP: next = cr_addr.
REQ-020 ns_sel 011 NEXT: next = inc.
REQ-021 ns_sel 100 BRANCH: next = cr_addr if cond, else inc.
REQ-022 ns_sel 101 WAIT: cond true -> next = inc, wait_cnt cleared.
REQ-023 WAIT with cond false: hold current_state; increment wait_cnt.
REQ-024 WAIT timeout: cond false with wait_cnt == TIMEOUT-1 -> next = 0, moc_timeout set, wait_cnt cleared.
REQ-025 Result: the TIMEOUT-th consecutive false wait cycle forces state 0.
REQ-026 ns_sel 110 CALL: next = cr_addr; ret_reg <= inc same edge; a second CALL overwrites ret_reg.
REQ-027 ns_sel 111 RETURN: next = ret_reg; ret_reg unchanged.
REQ-028 wait_cnt SHALL clear on every edge where ns_sel != 101.
REQ-029 illegal_op SHALL be high exactly one cycle per illegal dispatch; back-to-back illegal dispatches give a continuous high.
REQ-030 moc_timeout SHALL stay high until reset; further timeouts leave it high.
REQ-031 All next-state logic SHALL be combinational from the present inputs and registers; one-cycle latency from inputs to current_state.

Reset
REQ-032 reset low SHALL immediately (no clock) force current_state=0, ret_reg=0, wait_cnt=0, illegal_op=0, moc_timeout=0.
REQ-033 While reset is low all registers SHALL hold reset values regardless of clk.
REQ-034 Reset asserted mid-WAIT or mid-CALL SHALL discard that operation; first edge after release evaluates from state 0.
REQ-035 Reset release SHALL be synchronous-safe; the first rising edge after release is a normal update.

Verification
REQ-036 Reset mid-run: state 9, reset low between edges -> current_state=0 at once, flags 0; release, NEXT -> 1.
REQ-037 Dispatch sweep: DISPATCH with each of the 6 opcodes -> 5,6,7,8,9,10.
REQ-038 Illegal dispatch: opcode 111111 -> state 0, illegal_op high exactly one cycle.
REQ-039 Wait/timeout, TIMEOUT=16, state 3, WAIT, cond_sel 00, moc=0: 15 edges hold 3; 16th edge -> state 0, moc_timeout=1.
REQ-040 Wait release: repeat REQ-039, moc=1 on 4th cycle -> state 4, moc_timeout=0.
REQ-041 Branch/call/return/wrap: BRANCH from 2, cr_addr 40, zero=1, inv=1 -> 3. CALL from 3, cr_addr 20 -> 20, ret_reg=4; RETURN -> 4. NEXT from 127 -> 0.
